imem_responder: RTL
===================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, instruction memory depth in 32-bit words (power of two, >=4).
REQ-002 SHALL have parameter WAIT_CYCLES, default 1, wait states between request accept and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid_i  input  1  fetch request present.
REQ-006 SHALL have port req_addr_i  input  DPW  byte address of the instruction (PCF).
REQ-007 SHALL have port req_ready_o  output  1  responder can accept a request this cycle.
REQ-008 SHALL have port flush_i  input  1  abort in-flight fetch (redirect/flushF).
REQ-009 SHALL have port rsp_valid_o  output  1  response present.
REQ-010 SHALL have port rsp_instr_o  output  DPW  fetched instruction word.
REQ-011 SHALL have port rsp_addr_o  output  DPW  byte address the response belongs to.
REQ-012 SHALL have port rsp_err_o  output  1  misaligned request flag, qualified by rsp_valid_o.
REQ-013 SHALL have port rsp_ready_i  input  1  consumer accepts the response.
REQ-014 SHALL have ports wr_en_i (input, 1), wr_addr_i (input, DPW), wr_data_i (input, DPW)  program-load write port, byte address.
REQ-015 SHALL have ports perf_rsp_cnt_o (output, 32) and perf_stall_cnt_o (output, 32)  performance counters.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 SHALL drive req_ready_o=1 in IDLE and in RESP when rsp_ready_i=1; 0 otherwise, and 0 whenever flush_i=1.
REQ-018 SHALL accept a request on a cycle with req_valid_i & req_ready_o, capturing req_addr_i.
REQ-019 SHALL, on accept with WAIT_CYCLES>0, go to WAIT, load the wait counter with WAIT_CYCLES-1 and decrement each cycle, moving to RESP when the counter is 0.
REQ-020 SHALL, on accept with WAIT_CYCLES=0, go directly to RESP; rsp_valid_o is high exactly 1+WAIT_CYCLES cycles after the accept edge.
REQ-021 SHALL hold rsp_valid_o, rsp_instr_o, rsp_addr_o and rsp_err_o stable in RESP until rsp_ready_i=1.
REQ-022 SHALL, in RESP with rsp_ready_i=1: go to IDLE if no new request, or accept the new request back-to-back (WAIT or RESP per REQ-019/020).
REQ-023 SHALL index memory with req_addr_i[log2(MEM_WORDS)+1:2]; upper address bits are ignored, so addresses wrap modulo MEM_WORDS*4.
REQ-024 SHALL, for req_addr_i[1:0]!=0, respond with rsp_err_o=1 and rsp_instr_o=32'h00000013 (NOP) after the same latency.
REQ-025 SHALL write wr_data_i to word wr_addr_i[log2(MEM_WORDS)+1:2] when wr_en_i=1 in any state; a fetch of the same word reads the old data if the write is on the read cycle and new data on any later cycle.
REQ-026 SHALL, when flush_i=1, go to IDLE next cycle with rsp_valid_o=0, discard any in-flight or pending response, and ignore a request presented in the same cycle.
REQ-027 SHALL keep rsp_valid_o=0 and req_ready_o=1 in IDLE.

Reset
REQ-028 SHALL, when rst=1, set state IDLE, rsp_valid_o=0, rsp_instr_o=0, rsp_addr_o=0, rsp_err_o=0, wait counter 0 and perf counters 0; rst overrides flush_i, requests and any in-flight fetch.
REQ-029 SHALL NOT clear memory contents on reset; writes with rst=1 are still performed.

Configuration
REQ-030 SHALL, with IMEM_RESPONDER_PERF_EN defined, increment perf_rsp_cnt_o on each rsp_valid_o&rsp_ready_i and perf_stall_cnt_o on each rsp_valid_o&!rsp_ready_i cycle, both wrapping at 2^32.
REQ-031 SHALL, without IMEM_RESPONDER_PERF_EN, tie both perf outputs to 0 and instantiate no counter logic.

Verification
REQ-032 SHALL cover: load word 4 = 32'h00500093, WAIT_CYCLES=1, request addr 0x10 at cycle N -> rsp_valid_o at N+2, rsp_instr_o=32'h00500093, rsp_addr_o=0x10, rsp_err_o=0.
REQ-033 SHALL cover: rsp_ready_i held 0 for 3 cycles in RESP -> outputs stable, perf_stall_cnt_o=3 with PERF_EN defined, 0 without.
REQ-034 SHALL cover: flush_i=1 during WAIT with req_valid_i=1 -> next cycle IDLE, rsp_valid_o=0, no response ever produced for either request.
REQ-035 SHALL cover: request addr 0x102 -> rsp_err_o=1, rsp_instr_o=32'h00000013.
REQ-036 SHALL cover: WAIT_CYCLES=0, continuous req_valid_i and rsp_ready_i on addrs 0,4,8 -> one response per cycle, in order; MEM_WORDS=256 request 0x400 returns word 0.
REQ-037 SHALL cover: rst=1 asserted in RESP -> next cycle rsp_valid_o=0, state IDLE, memory contents unchanged on re-fetch.

Source files
------------

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
//
// Instruction-memory responder for a fetch stage. It accepts one fetch request
// at a time (or one per cycle back-to-back), waits WAIT_CYCLES wait states and
// then presents the instruction word with a valid/ready handshake. A flush
// aborts whatever is in flight. A separate write port loads the program image.
//
// Build option:
//   IMEM_RESPONDER_PERF_EN  when defined, adds the response and stall
//                           performance counters; otherwise both perf outputs
//                           are tied to zero and no counter logic exists.
//
// Parameters:
//   MEM_WORDS    memory depth in 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  wait states between accept and response (0..15)
//   DPW          data path width; the instruction format fixes this at 32
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid_i/req_addr_i   fetch request and its byte address
//   req_ready_o              request can be accepted this cycle
//   flush_i                  drop any in-flight or pending response
//   rsp_valid_o/rsp_ready_i  response handshake
//   rsp_instr_o/rsp_addr_o   instruction word and the address it belongs to
//   rsp_err_o                misaligned request (instruction forced to NOP)
//   wr_en_i/wr_addr_i/wr_data_i  program-load write port (byte address)
//   perf_rsp_cnt_o           completed responses
//   perf_stall_cnt_o         cycles a response waited on the consumer
// -----------------------------------------------------------------------------
module imem_responder #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int DPW         = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid_i,
    input  logic [DPW-1:0] req_addr_i,
    output logic           req_ready_o,
    input  logic           flush_i,
    output logic           rsp_valid_o,
    output logic [DPW-1:0] rsp_instr_o,
    output logic [DPW-1:0] rsp_addr_o,
    output logic           rsp_err_o,
    input  logic           rsp_ready_i,
    input  logic           wr_en_i,
    input  logic [DPW-1:0] wr_addr_i,
    input  logic [DPW-1:0] wr_data_i,
    output logic [31:0]    perf_rsp_cnt_o,
    output logic [31:0]    perf_stall_cnt_o
);

    localparam int AW = $clog2(MEM_WORDS);
    // Counter reload value; a zero-wait build never enters WAIT, so the
    // clamp only keeps the constant legal.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [DPW-1:0] NOP_INSTR = DPW'(32'h0000_0013);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     wait_cnt_q, wait_cnt_d;
    logic           accept;
    logic [DPW-1:0] rsp_addr_q;
    logic           rsp_err_q;
    logic [DPW-1:0] rdata_q;
    logic [DPW-1:0] mem_q [MEM_WORDS];

    logic [AW-1:0]  rd_idx;
    logic [AW-1:0]  wr_idx;

    // Only the word-index bits of the write address matter; the rest wrap.
    logic           unused_wr_addr_bits;

    assign rd_idx = req_addr_i[AW+1:2];
    assign wr_idx = wr_addr_i[AW+1:2];
    assign unused_wr_addr_bits = ^{wr_addr_i[DPW-1:AW+2], wr_addr_i[1:0]};

    assign accept = req_valid_i & req_ready_o;

    // ---------------------------------------------------------------- FSM ---
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    if (accept) begin
                        if (WAIT_CYCLES > 0) begin
                            state_d    = WAIT;
                            wait_cnt_d = WAIT_LOAD;
                        end else begin
                            state_d = RESP;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A flush wins over everything except reset.
        if (flush_i) begin
            state_d    = IDLE;
            wait_cnt_d = 4'd0;
        end
    end

    always_comb begin
        rsp_valid_o = (state_q == RESP);
        req_ready_o = !flush_i && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready_i));
    end

    // ------------------------------------------------------ request capture --
    // Address and alignment flag are captured on accept and held until the
    // next accept, so the response stays stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_addr_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (accept) begin
            rsp_addr_q <= req_addr_i;
            rsp_err_q  <= (req_addr_i[1:0] != 2'b00);
        end
    end

    // ------------------------------------------------------------ memory ---
    // Contents survive reset; the load port writes in every state.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx] <= wr_data_i;
        end
    end

    // Registered read on the accept edge: a same-edge write returns old data,
    // and the read register doubles as the held response word.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (accept) begin
            rdata_q <= mem_q[rd_idx];
        end
    end

    assign rsp_addr_o  = rsp_addr_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_instr_o = rsp_err_q ? NOP_INSTR : rdata_q;

    // ------------------------------------------------------- perf counters --
`ifdef IMEM_RESPONDER_PERF_EN
    logic [31:0] perf_rsp_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_rsp_q   <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (rsp_valid_o && rsp_ready_i) begin
                perf_rsp_q <= perf_rsp_q + 32'd1;
            end
            if (rsp_valid_o && !rsp_ready_i) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_rsp_cnt_o   = perf_rsp_q;
    assign perf_stall_cnt_o = perf_stall_q;
`else
    assign perf_rsp_cnt_o   = 32'd0;
    assign perf_stall_cnt_o = 32'd0;
`endif

endmodule
